// File: rtl/jtag_tap_ctrl.sv
// rtl/jtag_tap_ctrl.sv - IEEE 1149.1 TAP controller, instruction register, BYPASS/IDCODE registers and TDO mux
module jtag_tap_ctrl #(
    parameter int          IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_5001
) (
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    input  logic       tdi,
    output logic       tdo,
    output logic       tdo_en,
    output logic       bsr_tdi,
    input  logic       bsr_tdo,
    output logic       bsr_capture,
    output logic       bsr_shift,
    output logic       bsr_update,
    output logic       bsr_mode,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SHIFT_DR = 4'd4,
        EX1_DR   = 4'd5,
        PAUSE_DR = 4'd6,
        EX2_DR   = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SHIFT_IR = 4'd11,
        EX1_IR   = 4'd12,
        PAUSE_IR = 4'd13,
        EX2_IR   = 4'd14,
        UPD_IR   = 4'd15
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] IR_EXTEST  = '0;
    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = IR_WIDTH'(2);
    // Alternating 01 pattern keeps the mandatory 2'b01 in the LSBs for any width
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(32'h5555_5555);

    tap_state_t          state;
    tap_state_t          next_state;
    logic [IR_WIDTH-1:0] ir_sr;
    logic [IR_WIDTH-1:0] ir_active;
    logic [31:0]         id_sr;
    logic                bypass_reg;
    logic                bsr_sel;
    logic                id_sel;
    logic                dr_tdo;

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            state <= TLR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            TLR:      next_state = tms ? TLR      : RTI;
            RTI:      next_state = tms ? SEL_DR   : RTI;
            SEL_DR:   next_state = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   next_state = tms ? EX1_DR   : SHIFT_DR;
            SHIFT_DR: next_state = tms ? EX1_DR   : SHIFT_DR;
            EX1_DR:   next_state = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: next_state = tms ? EX2_DR   : PAUSE_DR;
            EX2_DR:   next_state = tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   next_state = tms ? SEL_DR   : RTI;
            SEL_IR:   next_state = tms ? TLR      : CAP_IR;
            CAP_IR:   next_state = tms ? EX1_IR   : SHIFT_IR;
            SHIFT_IR: next_state = tms ? EX1_IR   : SHIFT_IR;
            EX1_IR:   next_state = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: next_state = tms ? EX2_IR   : PAUSE_IR;
            EX2_IR:   next_state = tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   next_state = tms ? SEL_DR   : RTI;
            default:  next_state = TLR;
        endcase
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            ir_sr <= '0;
        end else if (state == CAP_IR) begin
            ir_sr <= IR_CAPTURE;
        end else if (state == SHIFT_IR) begin
            ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
        end
    end

    // Forcing on next_state==TLR means the register already reads IDCODE while in TLR
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            ir_active <= IR_IDCODE;
        end else if (next_state == TLR) begin
            ir_active <= IR_IDCODE;
        end else if (state == UPD_IR) begin
            ir_active <= ir_sr;
        end
    end

    always_comb begin
        bsr_sel = (ir_active == IR_EXTEST) || (ir_active == IR_SAMPLE);
        id_sel  = (ir_active == IR_IDCODE);
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            id_sr <= '0;
        end else if (state == CAP_DR) begin
            id_sr <= IDCODE_VAL;
        end else if (state == SHIFT_DR && id_sel) begin
            id_sr <= {tdi, id_sr[31:1]};
        end
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            bypass_reg <= 1'b0;
        end else if (state == CAP_DR) begin
            bypass_reg <= 1'b0;
        end else if (state == SHIFT_DR) begin
            bypass_reg <= tdi;
        end
    end

    always_comb begin
        if (bsr_sel) begin
            dr_tdo = bsr_tdo;
        end else if (id_sel) begin
            dr_tdo = id_sr[0];
        end else begin
            dr_tdo = bypass_reg;
        end
    end

    // Falling-edge outputs give the receiving device a half cycle of setup
    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            tdo      <= 1'b0;
            tdo_en   <= 1'b0;
            bsr_mode <= 1'b0;
        end else begin
            tdo_en   <= (state == SHIFT_DR) || (state == SHIFT_IR);
            bsr_mode <= (ir_active == IR_EXTEST);
            if (state == SHIFT_IR) begin
                tdo <= ir_sr[0];
            end else if (state == SHIFT_DR) begin
                tdo <= dr_tdo;
            end else begin
                tdo <= 1'b0;
            end
        end
    end

    assign bsr_tdi     = tdi;
    assign bsr_capture = bsr_sel && (state == CAP_DR);
    assign bsr_shift   = bsr_sel && (state == SHIFT_DR);
    assign bsr_update  = bsr_sel && (state == UPD_DR);
    assign state_o     = state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb/tb_jtag_tap_ctrl.sv - self-checking bench for jtag_tap_ctrl against a scan-level reference model
module tb_jtag_tap_ctrl;

    localparam logic [31:0] IDV = 32'h1000_5001;

    logic       tck = 1'b0;
    logic       trst;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_en;
    logic       bsr_tdi;
    logic       bsr_tdo;
    logic       bsr_capture;
    logic       bsr_shift;
    logic       bsr_update;
    logic       bsr_mode;
    logic [3:0] state_o;

    jtag_tap_ctrl #(.IR_WIDTH(4), .IDCODE_VAL(IDV)) dut (
        .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
        .bsr_tdi(bsr_tdi), .bsr_tdo(bsr_tdo), .bsr_capture(bsr_capture),
        .bsr_shift(bsr_shift), .bsr_update(bsr_update), .bsr_mode(bsr_mode),
        .state_o(state_o)
    );

    always #5 tck = ~tck;

    int n_checks = 0;
    int n_pass   = 0;

    int          m_state;
    logic [3:0]  m_ir_sr;
    logic [3:0]  m_ir;
    logic [31:0] m_id;
    logic        m_byp;
    logic        e_tdo;
    logic        e_en;
    logic        e_mode;
    int          cnt_cap;
    int          cnt_shift;
    int          cnt_upd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // TAP graph: both columns share one shape, offset by their SELECT state
    function automatic int tap_next(input int s, input logic t);
        int base;
        int r;
        if (s == 0) return t ? 0 : 1;
        if (s == 1) return t ? 2 : 1;
        if (s == 2) return t ? 9 : 3;
        if (s == 9) return t ? 0 : 10;
        base = (s < 9) ? 2 : 9;
        r = s - base;
        case (r)
            1, 2:    return base + (t ? 3 : 2);
            3:       return base + (t ? 6 : 4);
            4:       return base + (t ? 5 : 4);
            5:       return base + (t ? 6 : 2);
            default: return t ? 2 : 1;
        endcase
    endfunction

    // 2 = boundary scan, 1 = idcode, 0 = bypass
    function automatic int dr_kind(input logic [3:0] ir);
        if (ir == 4'd0 || ir == 4'd2) return 2;
        if (ir == 4'd1) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_ir = 4'd1; m_ir_sr = 4'd0; m_id = 32'd0; m_byp = 1'b0;
        e_tdo = 1'b0; e_en = 1'b0; e_mode = 1'b0;
    endtask

    task automatic model_posedge(input logic t, input logic d);
        int s;
        s = m_state;
        if (s == 10) m_ir_sr = 4'b0101;
        if (s == 11) m_ir_sr = {d, m_ir_sr[3:1]};
        if (s == 3) begin m_id = IDV; m_byp = 1'b0; end
        if (s == 4) begin
            if (m_ir == 4'd1) m_id = {d, m_id[31:1]};
            m_byp = d;
        end
        if (s == 15) m_ir = m_ir_sr;
        m_state = tap_next(s, t);
        if (m_state == 0) m_ir = 4'd1;
    endtask

    task automatic model_negedge();
        e_en = (m_state == 4) || (m_state == 11);
        e_mode = (m_ir == 4'd0);
        if (m_state == 11) e_tdo = m_ir_sr[0];
        else if (m_state == 4) begin
            case (dr_kind(m_ir))
                2:       e_tdo = bsr_tdo;
                1:       e_tdo = m_id[0];
                default: e_tdo = m_byp;
            endcase
        end else e_tdo = 1'b0;
    endtask

    task automatic compare();
        logic sel;
        sel = (dr_kind(m_ir) == 2);
        check("state", state_o, m_state);
        check("tdo", tdo, e_tdo);
        check("tdo_en", tdo_en, e_en);
        check("bsr_mode", bsr_mode, e_mode);
        check("bsr_capture", bsr_capture, sel && m_state == 3);
        check("bsr_shift", bsr_shift, sel && m_state == 4);
        check("bsr_update", bsr_update, sel && m_state == 8);
        check("bsr_tdi", bsr_tdi, tdi);
    endtask

    task automatic step(input logic t, input logic d);
        tms = t; tdi = d; bsr_tdo = 1'($urandom_range(0, 1));
        @(posedge tck);
        model_posedge(t, d);
        @(negedge tck);
        model_negedge();
        #1;
        compare();
        cnt_cap   += int'(bsr_capture);
        cnt_shift += int'(bsr_shift);
        cnt_upd   += int'(bsr_update);
    endtask

    task automatic scan_ir(input logic [3:0] din, output logic [3:0] dout);
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            dout[i] = tdo;
            step(i == 3, din[i]);
        end
        step(1'b1, 1'b0); step(1'b0, 1'b0);
    endtask

    task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            step(i == n - 1, din[i]);
        end
        step(1'b1, 1'b0); step(1'b0, 1'b0);
    endtask

    task automatic clear_counts();
        cnt_cap = 0; cnt_shift = 0; cnt_upd = 0;
    endtask

    task automatic async_reset();
        trst = 1'b0;
        #1;
        model_reset();
        compare();
        #1;
        trst = 1'b1;
    endtask

    logic [3:0]  irq;
    logic [63:0] dq;

    initial begin
        trst = 1'b0; tms = 1'b1; tdi = 1'b0; bsr_tdo = 1'b0;
        clear_counts();
        model_reset();
        #2;
        compare();
        #5;
        trst = 1'b1;
        step(1'b0, 1'b0);

        scan_dr(32, {$urandom, $urandom}, dq);
        check("idcode_scan", dq[31:0], IDV);
        check("idcode_no_bsr_shift", cnt_shift, 0);

        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)));
        check("five_tms_tlr", state_o, 4'd0);
        step(1'b0, 1'b0);
        scan_dr(32, 64'd0, dq);
        check("tlr_ir_idcode", dq[31:0], IDV);

        scan_ir(4'hF, irq);
        check("ir_capture", irq, 4'b0101);
        scan_dr(5, 64'h0D, dq);
        check("bypass_delay", dq[4:0], 5'h1A);

        scan_ir(4'h0, irq);
        check("extest_mode", bsr_mode, 1'b1);
        clear_counts();
        scan_dr(8, {$urandom, $urandom}, dq);
        check("extest_cap_cnt", cnt_cap, 1);
        check("extest_shift_cnt", cnt_shift, 8);
        check("extest_upd_cnt", cnt_upd, 1);

        scan_ir(4'b0110, irq);
        check("undef_mode", bsr_mode, 1'b0);
        clear_counts();
        scan_dr(5, 64'h0D, dq);
        check("undef_bypass", dq[4:0], 5'h1A);
        check("undef_bsr_ctrl", cnt_cap + cnt_shift + cnt_upd, 0);

        scan_ir(4'h0, irq);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b0, 1'b1); step(1'b0, 1'b0);
        clear_counts();
        trst = 1'b0;
        #1;
        check("rst_state", state_o, 4'd0);
        check("rst_mode", bsr_mode, 1'b0);
        check("rst_shift", bsr_shift, 1'b0);
        check("rst_tdo", tdo, 1'b0);
        check("rst_tdo_en", tdo_en, 1'b0);
        model_reset();
        #1;
        trst = 1'b1;
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        check("rst_no_update", cnt_upd, 0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 399) == 0) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
- IEEE 1149.1 TAP controller and instruction register that sits directly upstream of the boundary-scan register chain.
- Decodes TMS and TDI into the control signals that sequence the chain: shift, capture, update and mode.
- Owns the BYPASS and IDCODE data registers.
- Muxes the selected register onto TDO.

Parameters:
- IR_WIDTH, 4, instruction register width in bits.
- IDCODE_VAL, 32'h1000_5001, device ID captured in CAPTURE_DR under IDCODE. Bit 0 must be 1.

Ports:
- tck  in  1  JTAG test clock; all state changes on posedge, TDO on negedge.
- trst  in  1  asynchronous active-low reset.
- tms  in  1  test mode select, sampled on posedge tck.
- tdi  in  1  test data in, sampled on posedge tck.
- tdo  out  1  test data out, updated on negedge tck.
- tdo_en  out  1  high while in SHIFT_DR or SHIFT_IR, registered on negedge.
- bsr_tdi  out  1  serial input to BSR chain; equals tdi.
- bsr_tdo  in  1  serial output from last BSR stage.
- bsr_capture  out  1  BSR parallel capture enable.
- bsr_shift  out  1  BSR shift enable.
- bsr_update  out  1  BSR update strobe.
- bsr_mode  out  1  0 = functional passthrough, 1 = drive pins from BSR (EXTEST).
- state_o  out  4  current TAP state encoding, for debug.

Behaviour:
- **States** (4-bit encoding 0..15 in this order): TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SHIFT_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR.
- **Transitions** follow 1149.1 exactly, advancing on posedge tck:
  - TLR: tms=1 -> TLR, tms=0 -> RTI.
  - RTI: 1 -> SEL_DR, 0 -> RTI.
  - SEL_DR: 1 -> SEL_IR, 0 -> CAP_DR.
  - SEL_IR: 1 -> TLR, 0 -> CAP_IR.
  - CAP_x: 1 -> EX1_x, 0 -> SHIFT_x.
  - SHIFT_x: 1 -> EX1_x, 0 -> SHIFT_x.
  - EX1_x: 1 -> UPD_x, 0 -> PAUSE_x.
  - PAUSE_x: 1 -> EX2_x, 0 -> PAUSE_x.
  - EX2_x: 1 -> UPD_x, 0 -> SHIFT_x.
  - UPD_x: 1 -> SEL_DR, 0 -> RTI.
  - Five consecutive tms=1 reach TLR from any state.
- **Instructions:**
  - EXTEST = 4'b0000: DR = BSR, bsr_mode=1.
  - IDCODE = 4'b0001: DR = 32-bit ID register.
  - SAMPLE_PRELOAD = 4'b0010: DR = BSR, bsr_mode=0.
  - BYPASS = 4'b1111, and every undefined code: DR = 1-bit bypass register.
- **IR shift register:**
  - CAP_IR loads 4'b0101 (LSBs = 2'b01 per standard).
  - SHIFT_IR shifts right: tdi enters MSB, LSB exits to tdo.
- **Active IR:**
  - Loaded from the IR shift register on the posedge that leaves UPD_IR.
  - Forced to IDCODE in TLR and on trst.
- **ID register:** CAP_DR loads IDCODE_VAL; SHIFT_DR shifts right, LSB first.
- **Bypass register:** CAP_DR loads 0; SHIFT_DR loads tdi, giving exactly one tck of delay tdi -> tdo.
- **BSR controls:**
  - Let bsr_sel = (active IR is EXTEST or SAMPLE_PRELOAD).
  - bsr_capture = bsr_sel && state==CAP_DR.
  - bsr_shift = bsr_sel && state==SHIFT_DR.
  - bsr_update = bsr_sel && state==UPD_DR; one tck wide.
  - All three are combinational from the state register (glitch-free; state changes only on posedge).
- **bsr_mode:** registered on negedge tck. Becomes 1 the negedge after UPD_IR completes with EXTEST, and stays 1 until a different instruction is updated or TLR is entered.
- **TDO mux:**
  - In SHIFT_IR: IR shift LSB.
  - In SHIFT_DR: the selected DR serial output (ID LSB, bypass bit, or bsr_tdo).
  - Registered on negedge tck; tdo=0 and tdo_en=0 outside shift states.
- **Reset:**
  - trst low asynchronously forces: state=TLR, active IR=IDCODE, IR shift=0, ID shift=0, bypass=0, tdo=0, tdo_en=0, bsr_mode=0.
  - bsr_capture, bsr_shift and bsr_update are 0 as a consequence of TLR.
  - Reset mid-shift discards partial IR/DR contents; no update strobe is issued.
- **PAUSE states:** hold all shift registers unchanged, and tdo_en=0.

Test Plan:
- trst pulse low, release; tms=0 -> RTI, then go to SHIFT_DR and shift 32 bits -> tdo emits IDCODE_VAL LSB first (first bit 1); bsr_shift stays 0 throughout.
- From SHIFT_DR, apply tms=1 for 5 tck -> state_o=TLR (0) after the 5th edge; active IR reads back as IDCODE.
- Shift IR=4'b1111, then go to SHIFT_DR and drive tdi pattern 1,0,1,1 -> tdo shows 0 (captured bypass), then 1,0,1,1, each one tck late. During SHIFT_IR, the first 4 tdo bits are 1,0,1,0 (capture value 0101 LSB first).
- Load EXTEST -> bsr_mode rises on the negedge after UPD_IR. Then run a DR scan: bsr_capture high for exactly one tck in CAP_DR, bsr_shift high for each SHIFT_DR cycle, bsr_update high for one tck in UPD_DR, and tdo tracks bsr_tdo delayed to the negedge.
- Load undefined code 4'b0110 -> DR path behaves as BYPASS (1-cycle delay); bsr_* controls stay 0.
- Pull trst low while in SHIFT_DR under EXTEST -> immediately state_o=0, bsr_mode=0, bsr_shift=0, tdo=0; no bsr_update pulse occurs.
